hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It produces forwarding selects for the EX-stage operand muxes and load-use stalls. It handles branch-taken flushes and multi-cycle EX-op stalls, which are sequenced by an internal FSM. Its outputs drive the enables and clears of the IF/ID, ID/EX and EX/MEM pipeline registers, and it keeps saturating stall and flush event counters for performance monitoring.

## Interface
- MC_STALL, 3, stall cycles per multi-cycle EX op (≥1); the op occupies EX for MC_STALL+1 cycles
- CNT_W, 32, event counter width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- Rs1D, Rs2D  in  5 each  source registers in Decode
- Rs1E, Rs2E, RdE  in  5 each  source/destination registers in Execute
- ResultSrcE0  in  1  instruction in EX is a load
- PCSrcE  in  1  branch/jump taken, resolved in EX
- McStartE  in  1  instruction in EX is a multi-cycle op (mul/div)
- RdM, RegWriteM  in  5/1  Memory-stage destination and write enable
- RdW, RegWriteW  in  5/1  Writeback-stage destination and write enable
- CntClr  in  1  synchronous clear of both event counters
- StallF, StallD, StallE  out  1 each  hold PC, IF/ID and ID/EX registers
- FlushD, FlushE, FlushM  out  1 each  clear IF/ID, ID/EX and EX/MEM registers
- ForwardAE, ForwardBE  out  2 each  00 register file, 01 from W, 10 from M
- McBusy  out  1  multi-cycle stall active
- McDone  out  1  one-cycle pulse on the release cycle
- StallCount, FlushCount  out  CNT_W each  event counters

## Operation
- Forwarding (combinational, always active): ForwardAE = 10 if RegWriteM & RdM≠0 & RdM==Rs1E. Otherwise 01 if RegWriteW & RdW≠0 & RdW==Rs1E. Otherwise 00. M has priority over W. ForwardBE uses the same rule with Rs2E.
- lwStall = ResultSrcE0 & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- mcStall = (state==IDLE & McStartE) | state==BUSY.
- Priority: mcStall > PCSrcE > lwStall.
  - mcStall: StallF=StallD=StallE=1, FlushM=1, FlushD=FlushE=0.
  - else PCSrcE: FlushD=1, FlushE=1, no stalls.
  - else lwStall: StallF=StallD=1, FlushE=1.
  - else: all outputs 0.
- McBusy = mcStall.
- Multi-cycle FSM states: IDLE, BUSY, DONE.
  - IDLE: on McStartE, load cnt ← MC_STALL−1. Go to DONE if MC_STALL==1, else to BUSY.
  - BUSY: if cnt==1, go to DONE; else cnt ← cnt−1.
  - DONE: no stall, McDone=1, McStartE ignored (the held op leaves EX at this edge). Next state IDLE.
  - A back-to-back multi-cycle op in EX on the cycle after DONE starts a new sequence normally.
- Counters:
  - StallCount +1 on every cycle StallD==1.
  - FlushCount +1 on every cycle FlushE==1.
  - Both saturate at 2^CNT_W−1.
  - CntClr zeroes both at the next edge and has priority over increment.
- The multi-cycle unit must latch its forwarded operands in the IDLE start cycle; M is bubbled during BUSY.

## Timing
- Reset: state=IDLE, cnt=0, StallCount=FlushCount=0, McDone=0. All other outputs are their combinational value with FSM idle.
- Reset mid-operation aborts the sequence immediately and asynchronously: stalls drop and the FSM returns to IDLE.
- Forward, stall and flush outputs are combinational from inputs and state, with zero-cycle latency.
- Multi-cycle op: stall is high for exactly MC_STALL consecutive cycles (the IDLE start cycle plus MC_STALL−1 BUSY cycles), then one DONE cycle with stall low and McDone high.
- Load-use: exactly one stall cycle. The load leaves EX, the next cycle sees ResultSrcE0=0, and no FSM is involved.
- Counters update at the edge following the event cycle.

## Test plan
- Forwarding: RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5 -> ForwardAE=10. With RdM=0 -> ForwardAE=01. With Rs2E=5, RegWriteW=0, RdM≠5 -> ForwardBE=00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; StallCount=1, FlushCount=1. Same with RdE=0 -> no stall.
- Branch vs load-use: PCSrcE=1 and lwStall conditions simultaneously -> FlushD=FlushE=1, StallF=StallD=0.
- Multi-cycle, MC_STALL=3: McStartE held high -> StallE=FlushM=1 for cycles 0–2, McDone=1 in cycle 3, IDLE in cycle 4; StallCount=3. With MC_STALL=1 -> one stall cycle, then DONE.
- Reset mid-BUSY: assert reset in cycle 1 of a sequence -> StallF/D/E drop immediately, counters read 0, and a fresh McStartE restarts a full MC_STALL sequence.
- Saturation/clear: CNT_W=4, 20 stall cycles -> StallCount=15. CntClr coincident with a stall -> 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : 5-stage RISC-V hazard unit. EX operand forwarding, load-use
//            stall, branch flush, multi-cycle EX-op stall sequencing, and
//            saturating stall/flush event counters.
// Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MC_STALL = 3,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             McStartE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             CntClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             McBusy,
  output logic             McDone,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // Down-counter only needs to hold MC_STALL-1.
  localparam int MCW = (MC_STALL > 1) ? $clog2(MC_STALL) : 1;
  localparam logic [MCW-1:0] CNT_INIT = MCW'(MC_STALL - 1);
  localparam logic [MCW-1:0] CNT_ONE  = MCW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [MCW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             mc_stall;
  logic             lw_stall;

  // Forwarding: M-stage result wins over W-stage result; x0 never forwards.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
  end

  assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Multi-cycle state register; reset aborts any sequence immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Multi-cycle sequencing: start cycle stalls, BUSY counts down, DONE releases.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_stall = 1'b0;
    McDone   = 1'b0;
    case (state_q)
      IDLE: begin
        if (McStartE) begin
          mc_stall = 1'b1;
          cnt_d    = CNT_INIT;
          state_d  = (MC_STALL == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        mc_stall = 1'b1;
        if (cnt_q == CNT_ONE) state_d = DONE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      DONE: begin
        // The held op leaves EX at this edge; McStartE is not a new op yet.
        McDone  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall/flush arbitration: multi-cycle > branch taken > load-use.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (mc_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign McBusy = mc_stall;

  // Saturating event counters; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (CntClr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallD && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (FlushE && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Self-checking bench for hazard_ctrl. Two instances share inputs:
//            A (MC_STALL=3, CNT_W=4) and B (MC_STALL=1, CNT_W=32).
// Revision : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  typedef struct packed {
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic       ResultSrcE0, PCSrcE, McStartE;
    logic [4:0] RdM;
    logic       RegWriteM;
    logic [4:0] RdW;
    logic       RegWriteW;
    logic       CntClr;
  } in_t;

  typedef struct packed {
    in_t        i;
    logic [1:0] fa, fb;
    logic       sf, sd, fd, fe;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       ResultSrcE0, PCSrcE, McStartE, RegWriteM, RegWriteW, CntClr;

  logic        a_StallF, a_StallD, a_StallE, a_FlushD, a_FlushE, a_FlushM, a_McBusy, a_McDone;
  logic [1:0]  a_ForwardAE, a_ForwardBE;
  logic [3:0]  a_StallCount, a_FlushCount;
  logic        b_StallF, b_StallD, b_StallE, b_FlushD, b_FlushE, b_FlushM, b_McBusy, b_McDone;
  logic [1:0]  b_ForwardAE, b_ForwardBE;
  logic [31:0] b_StallCount, b_FlushCount;

  hazard_ctrl #(.MC_STALL(3), .CNT_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .CntClr(CntClr),
    .StallF(a_StallF), .StallD(a_StallD), .StallE(a_StallE), .FlushD(a_FlushD),
    .FlushE(a_FlushE), .FlushM(a_FlushM), .ForwardAE(a_ForwardAE), .ForwardBE(a_ForwardBE),
    .McBusy(a_McBusy), .McDone(a_McDone), .StallCount(a_StallCount), .FlushCount(a_FlushCount)
  );

  hazard_ctrl #(.MC_STALL(1), .CNT_W(32)) u_dut_b (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .McStartE(McStartE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW), .CntClr(CntClr),
    .StallF(b_StallF), .StallD(b_StallD), .StallE(b_StallE), .FlushD(b_FlushD),
    .FlushE(b_FlushE), .FlushM(b_FlushM), .ForwardAE(b_ForwardAE), .ForwardBE(b_ForwardBE),
    .McBusy(b_McBusy), .McDone(b_McDone), .StallCount(b_StallCount), .FlushCount(b_FlushCount)
  );

  // Per-instance views for the reference model.
  logic [7:0]  flg [2];
  logic [3:0]  fwd [2];
  logic [31:0] sc  [2];
  logic [31:0] fc  [2];
  assign flg[0] = {a_StallF, a_StallD, a_StallE, a_FlushD, a_FlushE, a_FlushM, a_McBusy, a_McDone};
  assign flg[1] = {b_StallF, b_StallD, b_StallE, b_FlushD, b_FlushE, b_FlushM, b_McBusy, b_McDone};
  assign fwd[0] = {a_ForwardAE, a_ForwardBE};
  assign fwd[1] = {b_ForwardAE, b_ForwardBE};
  assign sc[0]  = 32'(a_StallCount);
  assign fc[0]  = 32'(a_FlushCount);
  assign sc[1]  = b_StallCount;
  assign fc[1]  = b_FlushCount;

  int errors = 0;
  int checks = 0;

  // Reference model state: position within a multi-cycle sequence
  // (0 = no sequence in flight, k = k-th cycle after the start cycle).
  int     MC   [2] = '{3, 1};
  longint MAXC [2] = '{64'd15, 64'hFFFF_FFFF};
  int     pos  [2] = '{0, 0};
  longint cntS [2] = '{0, 0};
  longint cntF [2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Compare both instances with the model for the current cycle, then advance
  // the model across the coming clock edge.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      logic mc, done, lw, sf, sd, se, fdd, fe, fm;
      if (reset) begin
        pos[d]  = 0;
        cntS[d] = 0;
        cntF[d] = 0;
      end
      mc   = (pos[d] == 0) ? McStartE : (pos[d] < MC[d]);
      done = (pos[d] != 0) && (pos[d] == MC[d]);
      lw   = ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      sf = 0; sd = 0; se = 0; fdd = 0; fe = 0; fm = 0;
      if (mc)          begin sf = 1; sd = 1; se = 1; fm = 1; end
      else if (PCSrcE) begin fdd = 1; fe = 1; end
      else if (lw)     begin sf = 1; sd = 1; fe = 1; end
      chk(d == 0 ? "A.flags" : "B.flags", 32'(flg[d]), 32'({sf, sd, se, fdd, fe, fm, mc, done}));
      chk(d == 0 ? "A.fwd" : "B.fwd", 32'(fwd[d]), 32'({fwd_sel(Rs1E), fwd_sel(Rs2E)}));
      chk(d == 0 ? "A.StallCount" : "B.StallCount", sc[d], 32'(cntS[d]));
      chk(d == 0 ? "A.FlushCount" : "B.FlushCount", fc[d], 32'(cntF[d]));
      if (!reset) begin
        if (pos[d] == 0)          pos[d] = McStartE ? 1 : 0;
        else if (pos[d] == MC[d]) pos[d] = 0;
        else                      pos[d] = pos[d] + 1;
        if (CntClr) begin
          cntS[d] = 0;
          cntF[d] = 0;
        end else begin
          if (sd && cntS[d] < MAXC[d]) cntS[d]++;
          if (fe && cntF[d] < MAXC[d]) cntF[d]++;
        end
      end
    end
  endtask

  task automatic apply(input in_t v);
    @(negedge clk);
    reset = v.reset; Rs1D = v.Rs1D; Rs2D = v.Rs2D; Rs1E = v.Rs1E; Rs2E = v.Rs2E;
    RdE = v.RdE; ResultSrcE0 = v.ResultSrcE0; PCSrcE = v.PCSrcE; McStartE = v.McStartE;
    RdM = v.RdM; RegWriteM = v.RegWriteM; RdW = v.RdW; RegWriteW = v.RegWriteW;
    CntClr = v.CntClr;
    #1;
    model_step();
  endtask

  vec_t tbl [8];

  initial begin
    in_t z, v;
    logic [3:0] exp_se, exp_dn;
    z = '0;
    reset = 1'b1; Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; PCSrcE = 0; McStartE = 0; RegWriteM = 0; RegWriteW = 0; CntClr = 0;

    // Reset state
    v = z; v.reset = 1'b1;
    apply(v);
    apply(v);
    chk("reset.flags", 32'(flg[0]), 32'h0);
    chk("reset.StallCount", 32'(a_StallCount), 32'h0);

    // Load-use from reset: one stall cycle, both counters become 1
    v = z; v.ResultSrcE0 = 1; v.RdE = 7; v.Rs2D = 7;
    apply(v);
    chk("lu.stall", 32'({a_StallF, a_StallD, a_FlushE}), 32'h7);
    apply(z);
    chk("lu.clear", 32'({a_StallF, a_StallD, a_FlushE}), 32'h0);
    chk("lu.StallCount", 32'(a_StallCount), 32'd1);
    chk("lu.FlushCount", 32'(a_FlushCount), 32'd1);

    // Combinational vector table (FSM idle)
    for (int k = 0; k < 8; k++) tbl[k] = '0;
    tbl[0].i = z; tbl[0].i.RegWriteM = 1; tbl[0].i.RdM = 5; tbl[0].i.RegWriteW = 1;
    tbl[0].i.RdW = 5; tbl[0].i.Rs1E = 5; tbl[0].fa = 2'b10;
    tbl[1].i = tbl[0].i; tbl[1].i.RdM = 0; tbl[1].fa = 2'b01;
    tbl[2].i = z; tbl[2].i.Rs2E = 5; tbl[2].i.Rs1E = 5; tbl[2].i.RegWriteM = 1;
    tbl[2].i.RdM = 3; tbl[2].i.RdW = 5;
    tbl[3].i = z; tbl[3].i.ResultSrcE0 = 1; tbl[3].i.RdE = 7; tbl[3].i.Rs2D = 7;
    tbl[3].sf = 1; tbl[3].sd = 1; tbl[3].fe = 1;
    tbl[4].i = tbl[3].i; tbl[4].i.RdE = 0; tbl[4].i.Rs2D = 0;
    tbl[5].i = tbl[3].i; tbl[5].i.PCSrcE = 1; tbl[5].fd = 1; tbl[5].fe = 1;
    tbl[6].i = z; tbl[6].i.RegWriteW = 1; tbl[6].i.RdW = 9; tbl[6].i.Rs2E = 9; tbl[6].fb = 2'b01;
    tbl[7].i = z; tbl[7].i.RdE = 7; tbl[7].i.Rs1D = 7;
    for (int k = 0; k < 8; k++) begin
      apply(tbl[k].i);
      chk($sformatf("tbl%0d.fwd", k), 32'({a_ForwardAE, a_ForwardBE}), 32'({tbl[k].fa, tbl[k].fb}));
      chk($sformatf("tbl%0d.ctl", k), 32'({a_StallF, a_StallD, a_FlushD, a_FlushE}),
          32'({tbl[k].sf, tbl[k].sd, tbl[k].fd, tbl[k].fe}));
    end

    // Multi-cycle op, McStartE held through DONE then dropped
    v = z; v.CntClr = 1;
    apply(v);
    exp_se = 4'b0111; exp_dn = 4'b1000;
    for (int c = 0; c < 5; c++) begin
      v = z; v.McStartE = (c < 4);
      apply(v);
      chk($sformatf("mc%0d.StallE", c), 32'(a_StallE), (c < 4) ? 32'(exp_se[c]) : 32'h0);
      chk($sformatf("mc%0d.McDone", c), 32'(a_McDone), (c < 4) ? 32'(exp_dn[c]) : 32'h0);
      if (c == 0) chk("mc1.B.stall", 32'(b_StallE), 32'h1);
      if (c == 1) chk("mc1.B.done", 32'(b_McDone), 32'h1);
    end
    chk("mc.StallCount", 32'(a_StallCount), 32'd3);

    // Reset in the first BUSY cycle, then a fresh full sequence
    v = z; v.McStartE = 1;
    apply(v);
    v = z; v.reset = 1;
    apply(v);
    chk("rst.stalls", 32'({a_StallF, a_StallD, a_StallE}), 32'h0);
    chk("rst.StallCount", 32'(a_StallCount), 32'h0);
    for (int c = 0; c < 4; c++) begin
      v = z; v.McStartE = (c == 0);
      apply(v);
      chk($sformatf("rst.seq%0d.StallE", c), 32'(a_StallE), (c < 3) ? 32'h1 : 32'h0);
    end

    // Saturation at 15 with CNT_W=4, then clear coincident with a stall
    v = z; v.CntClr = 1;
    apply(v);
    v = z; v.ResultSrcE0 = 1; v.RdE = 7; v.Rs2D = 7;
    for (int c = 0; c < 20; c++) apply(v);
    apply(z);
    chk("sat.StallCount", 32'(a_StallCount), 32'd15);
    chk("sat.B.StallCount", b_StallCount, 32'd20);
    v.CntClr = 1;
    apply(v);
    apply(z);
    chk("clr.StallCount", 32'(a_StallCount), 32'd0);
    chk("clr.FlushCount", 32'(b_FlushCount), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      v = z;
      v.Rs1D = 5'($urandom_range(0, 3)); v.Rs2D = 5'($urandom_range(0, 3));
      v.Rs1E = 5'($urandom_range(0, 3)); v.Rs2E = 5'($urandom_range(0, 3));
      v.RdE  = 5'($urandom_range(0, 3)); v.RdM  = 5'($urandom_range(0, 3));
      v.RdW  = 5'($urandom_range(0, 3));
      v.RegWriteM   = 1'($urandom_range(0, 1));
      v.RegWriteW   = 1'($urandom_range(0, 1));
      v.ResultSrcE0 = ($urandom_range(0, 2) == 0);
      v.PCSrcE      = ($urandom_range(0, 5) == 0);
      v.McStartE    = ($urandom_range(0, 3) == 0);
      v.CntClr      = ($urandom_range(0, 30) == 0);
      apply(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
